// File: rtl/sort_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sort_ctrl_pkg
// Shared types and elaboration-time helpers for the streaming sort controller.
//   state_t     : controller FSM states
//   cnt_width   : bits needed to hold 0..n inclusive
//   addr_width  : bits needed to address n entries (minimum 1)
//   pad_val     : filler element that sorts to the tail of the vector
// -----------------------------------------------------------------------------
package sort_ctrl_pkg;

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Widest element the pad helper can describe.
  localparam int MAX_DATA_W = 64;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // All-ones for an ascending sorter, zero for a descending one, so padding
  // always ends up behind the real elements. Callers take the low size_data bits.
  function automatic logic [MAX_DATA_W-1:0] pad_val(input bit is_asc, input int size_data);
    logic [MAX_DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      v[i] = is_asc && (i < size_data);
    end
    return v;
  endfunction

endpackage : sort_ctrl_pkg

// File: rtl/sort_elem_buf.sv
// -----------------------------------------------------------------------------
// sort_elem_buf
// NUM_ELEM x SIZE_DATA register array with clear-to-pad, whole-vector load and
// single-entry indexed write; every entry is visible in parallel.
// Priority per edge: clear > vector load > indexed write.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (entries -> PAD)
//   i_clr          : synchronous clear of every entry to PAD
//   i_ld_en        : load the whole vector from i_ld_data
//   i_wr_en        : write i_wr_data into entry i_wr_idx
//   o_data         : registered contents, all entries in parallel
// -----------------------------------------------------------------------------
module sort_elem_buf
  import sort_ctrl_pkg::*;
#(
  parameter int                   NUM_ELEM  = 8,
  parameter int                   SIZE_DATA = 8,
  parameter logic [SIZE_DATA-1:0] PAD       = '1,
  parameter int                   AW        = addr_width(NUM_ELEM)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_ld_en,
  input  logic [SIZE_DATA-1:0] i_ld_data [NUM_ELEM],
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_idx,
  input  logic [SIZE_DATA-1:0] i_wr_data,
  output logic [SIZE_DATA-1:0] o_data    [NUM_ELEM]
);

  logic [SIZE_DATA-1:0] r_mem [NUM_ELEM];

  // NOTE: this array is deliberately reset: the sorter sees it continuously,
  // and unwritten slots of a short job must already hold PAD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_ELEM; i++) r_mem[i] <= PAD;
    end else if (i_clr) begin
      for (int i = 0; i < NUM_ELEM; i++) r_mem[i] <= PAD;
    end else if (i_ld_en) begin
      for (int i = 0; i < NUM_ELEM; i++) r_mem[i] <= i_ld_data[i];
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_data = r_mem;

endmodule : sort_elem_buf

// File: rtl/sort_stream_ctrl.sv
// -----------------------------------------------------------------------------
// sort_stream_ctrl
// Streaming front end for a fixed-latency parallel sorter. Serial input beats
// fill a padded vector, the vector is held on o_sort_data while the sorter
// works, the sorted vector is captured after SORT_LAT edges and the first
// len entries are streamed out with valid/ready.
//   i_clk, i_rst_n                    : clock, asynchronous active-low reset
//   i_flush                           : synchronous job abort (wins over handshakes)
//   i_in_valid/i_in_data/i_in_last    : input stream, o_in_ready registered
//   o_sort_data / i_sort_data         : vector to / sorted vector from sorter
//   o_out_valid/o_out_data/o_out_last : output stream, i_out_ready from consumer
//   o_busy                            : job in flight (waiting or draining)
// -----------------------------------------------------------------------------
module sort_stream_ctrl
  import sort_ctrl_pkg::*;
#(
  parameter int IS_ASC    = 1,
  parameter int NUM_ELEM  = 8,
  parameter int SIZE_DATA = 8,
  parameter int SORT_LAT  = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  input  logic [SIZE_DATA-1:0] i_in_data,
  input  logic                 i_in_last,
  output logic                 o_in_ready,
  output logic [SIZE_DATA-1:0] o_sort_data [NUM_ELEM],
  input  logic [SIZE_DATA-1:0] i_sort_data [NUM_ELEM],
  output logic                 o_out_valid,
  output logic [SIZE_DATA-1:0] o_out_data,
  output logic                 o_out_last,
  input  logic                 i_out_ready,
  output logic                 o_busy
);

  localparam int CW = cnt_width(NUM_ELEM);   // cnt / len / idx
  localparam int AW = addr_width(NUM_ELEM);  // buffer entry address
  localparam int WW = cnt_width(SORT_LAT);   // sorter wait counter

  localparam logic [MAX_DATA_W-1:0] PAD_W = pad_val(IS_ASC != 0, SIZE_DATA);
  localparam logic [SIZE_DATA-1:0]  PAD   = PAD_W[SIZE_DATA-1:0];

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [CW-1:0]        r_len;
  logic [CW-1:0]        r_idx;
  logic [WW-1:0]        r_wait;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic [SIZE_DATA-1:0] r_out_data;
  logic                 r_busy;

  logic                 w_in_hs;
  logic                 w_out_hs;
  logic                 w_job_end;
  logic                 w_capture;
  logic                 w_drain_done;
  logic                 w_buf_clr;
  logic [CW-1:0]        w_idx_nxt;
  logic [AW-1:0]        w_rd_addr;
  logic                 w_nxt_last;
  logic [SIZE_DATA-1:0] w_out_buf [NUM_ELEM];
  logic [SIZE_DATA-1:0] w_no_vec  [NUM_ELEM];

  // Flush is folded into both handshakes so a beat offered alongside a flush
  // is neither stored nor consumed.
  assign w_in_hs      = (r_state == S_LOAD) && i_in_valid && r_in_ready && !i_flush;
  assign w_out_hs     = (r_state == S_DRAIN) && r_out_valid && i_out_ready && !i_flush;
  assign w_job_end    = w_in_hs && (i_in_last || (r_cnt == CW'(NUM_ELEM - 1)));
  assign w_capture    = (r_state == S_WAIT) && (r_wait == WW'(1)) && !i_flush;
  assign w_drain_done = w_out_hs && r_out_last;
  assign w_buf_clr    = i_flush || w_drain_done;

  // Look-ahead to the next output entry so o_out_data stays registered. When
  // idx is already the last entry the truncated address is never used.
  assign w_idx_nxt  = r_idx + CW'(1);
  assign w_rd_addr  = w_idx_nxt[AW-1:0];
  assign w_nxt_last = (w_idx_nxt == (r_len - CW'(1)));

  assign w_no_vec = '{default: '0};

  sort_elem_buf #(
    .NUM_ELEM  (NUM_ELEM),
    .SIZE_DATA (SIZE_DATA),
    .PAD       (PAD),
    .AW        (AW)
  ) u_in_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_buf_clr),
    .i_ld_en   (1'b0),
    .i_ld_data (w_no_vec),
    .i_wr_en   (w_in_hs),
    .i_wr_idx  (r_cnt[AW-1:0]),
    .i_wr_data (i_in_data),
    .o_data    (o_sort_data)
  );

  sort_elem_buf #(
    .NUM_ELEM  (NUM_ELEM),
    .SIZE_DATA (SIZE_DATA),
    .PAD       (PAD),
    .AW        (AW)
  ) u_out_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_buf_clr),
    .i_ld_en   (w_capture),
    .i_ld_data (i_sort_data),
    .i_wr_en   (1'b0),
    .i_wr_idx  ('0),
    .i_wr_data ('0),
    .o_data    (w_out_buf)
  );

  // NOTE: all FSM state and registered outputs use non-blocking assignments
  // so every branch sees the pre-edge values, matching the hardware.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else if (i_flush) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wait      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_in_hs) begin
            r_cnt <= r_cnt + CW'(1);
            if (w_job_end) begin
              r_len      <= r_cnt + CW'(1);
              r_wait     <= WW'(SORT_LAT);
              r_state    <= S_WAIT;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          // The sorted vector is sampled on the edge the counter reaches 0,
          // so the first output beat is valid SORT_LAT edges after job end.
          r_wait <= r_wait - WW'(1);
          if (w_capture) begin
            r_state     <= S_DRAIN;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_out_data  <= i_sort_data[0];
            r_out_last  <= (r_len == CW'(1));
          end
        end

        S_DRAIN: begin
          if (w_drain_done) begin
            r_state     <= S_LOAD;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_out_hs) begin
            r_idx      <= w_idx_nxt;
            r_out_data <= w_out_buf[w_rd_addr];
            r_out_last <= w_nxt_last;
          end
        end

        default: begin
          r_state <= S_LOAD;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_busy      = r_busy;

endmodule : sort_stream_ctrl

// File: tb/tb_sort_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sort_stream_ctrl
// Two controllers (ascending and descending sorter) share every input and are
// each attached to a behavioural fixed-latency sorter. Expected output beats
// are pushed to one queue per controller when a job is sent and popped as the
// controllers emit them.
// -----------------------------------------------------------------------------
module tb_sort_stream_ctrl;

  localparam int N   = 8;
  localparam int W   = 8;
  localparam int LAT = 6;

  typedef logic [W-1:0] vec_t [N];

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b1;
  logic         flush     = 1'b0;
  logic         in_valid  = 1'b0;
  logic [W-1:0] in_data   = '0;
  logic         in_last   = 1'b0;
  logic         out_ready = 1'b0;

  vec_t         sd_a, sd_d, srt_a, srt_d;
  logic         rdy_a, rdy_d, val_a, val_d, last_a, last_d, busy_a, busy_d;
  logic [W-1:0] data_a, data_d;

  int n_vec = 0;
  int n_err = 0;

  logic [W:0] q_a [$];
  logic [W:0] q_d [$];

  always #5 clk = ~clk;

  sort_stream_ctrl #(.IS_ASC(1), .NUM_ELEM(N), .SIZE_DATA(W), .SORT_LAT(LAT)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .i_in_data(in_data), .i_in_last(in_last), .o_in_ready(rdy_a),
    .o_sort_data(sd_a), .i_sort_data(srt_a),
    .o_out_valid(val_a), .o_out_data(data_a), .o_out_last(last_a), .i_out_ready(out_ready),
    .o_busy(busy_a)
  );

  sort_stream_ctrl #(.IS_ASC(0), .NUM_ELEM(N), .SIZE_DATA(W), .SORT_LAT(LAT)) dut_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .i_in_data(in_data), .i_in_last(in_last), .o_in_ready(rdy_d),
    .o_sort_data(sd_d), .i_sort_data(srt_d),
    .o_out_valid(val_d), .o_out_data(data_d), .o_out_last(last_d), .i_out_ready(out_ready),
    .o_busy(busy_d)
  );

  // Behavioural sorter: sorted data is ready to be sampled on the LAT-th edge
  // after the last change of its input vector.
  function automatic vec_t sort_vec(input vec_t v, input bit asc);
    vec_t         r;
    logic [W-1:0] t;
    r = v;
    for (int i = 0; i < N - 1; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        if (asc ? (r[j] > r[j+1]) : (r[j] < r[j+1])) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
      end
    end
    return r;
  endfunction

  vec_t pipe_a [LAT-1];
  vec_t pipe_d [LAT-1];

  always @(posedge clk) begin
    pipe_a[0] <= sort_vec(sd_a, 1'b1);
    pipe_d[0] <= sort_vec(sd_d, 1'b0);
    for (int k = 1; k < LAT - 1; k++) begin
      pipe_a[k] <= pipe_a[k-1];
      pipe_d[k] <= pipe_d[k-1];
    end
  end

  assign srt_a = pipe_a[LAT-2];
  assign srt_d = pipe_d[LAT-2];

  // Producer side of the scoreboard: offers len beats, waits for each accept,
  // and queues the expected sorted beats for both controllers.
  task automatic send_job(input vec_t vals, input int len, input bit use_last, input bit expect_out);
    logic [W-1:0] s [N];
    logic [W-1:0] t;
    bit           hs;
    int           guard;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data  = vals[i];
      in_last  = use_last && (i == len - 1);
      hs       = 1'b0;
      guard    = 0;
      while (!hs && guard < 50) begin
        hs = rdy_a;
        @(posedge clk); #1;
        guard++;
      end
      n_vec++;
      if (!hs) begin
        n_err++;
        $display("FAIL accept_timeout: beat %0d not accepted, want accepted", i);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (expect_out) begin
      for (int i = 0; i < N; i++) s[i] = vals[i];
      for (int i = 0; i < len - 1; i++) begin
        for (int j = 0; j < len - 1 - i; j++) begin
          if (s[j] > s[j+1]) begin
            t = s[j]; s[j] = s[j+1]; s[j+1] = t;
          end
        end
      end
      for (int i = 0; i < len; i++) begin
        q_a.push_back({(i == len - 1), s[i]});
        q_d.push_back({(i == len - 1), s[len - 1 - i]});
      end
    end
  endtask

  // Consumer side of the scoreboard. With bp set, i_out_ready follows 1,0,0,1.
  task automatic drain(input int nbeats, input bit bp, input bit full);
    int         got;
    int         cyc;
    bit         stalled;
    logic [W:0] held_a, held_d, exp;
    got = 0; cyc = 0; stalled = 1'b0; held_a = '0; held_d = '0;
    while (got < nbeats && cyc < 300) begin
      out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
      if (stalled) begin
        n_vec++;
        if ({last_a, data_a} !== held_a || {last_d, data_d} !== held_d) begin
          n_err++;
          $display("FAIL stall_stable: got %h/%h want %h/%h", {last_a, data_a}, {last_d, data_d}, held_a, held_d);
        end
      end
      if (val_a || val_d) begin
        n_vec++;
        if (rdy_a !== 1'b0 || rdy_d !== 1'b0 || busy_a !== 1'b1) begin
          n_err++;
          $display("FAIL ready_in_drain: in_ready %b/%b busy %b want 0/0 busy 1", rdy_a, rdy_d, busy_a);
        end
        if (out_ready) begin
          n_vec++;
          if (q_a.size() == 0) begin
            n_err++;
            $display("FAIL extra_beat_a: got %h want no beat", {last_a, data_a});
          end else begin
            exp = q_a.pop_front();
            if (val_a !== 1'b1 || {last_a, data_a} !== exp) begin
              n_err++;
              $display("FAIL beat_asc: got v%b %h want v1 %h", val_a, {last_a, data_a}, exp);
            end
          end
          n_vec++;
          if (q_d.size() == 0) begin
            n_err++;
            $display("FAIL extra_beat_d: got %h want no beat", {last_d, data_d});
          end else begin
            exp = q_d.pop_front();
            if (val_d !== 1'b1 || {last_d, data_d} !== exp) begin
              n_err++;
              $display("FAIL beat_desc: got v%b %h want v1 %h", val_d, {last_d, data_d}, exp);
            end
          end
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_a  = {last_a, data_a};
          held_d  = {last_d, data_d};
        end
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    n_vec++;
    if (got != nbeats) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d beats want %0d", got, nbeats);
    end
    if (full) begin
      n_vec++;
      if (val_a !== 1'b0 || val_d !== 1'b0 || rdy_a !== 1'b1 || rdy_d !== 1'b1 || busy_a !== 1'b0) begin
        n_err++;
        $display("FAIL after_drain: valid %b/%b ready %b/%b busy %b want 0/0 1/1 0",
                 val_a, val_d, rdy_a, rdy_d, busy_a);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (rdy_a !== 1'b1 || val_a !== 1'b0 || last_a !== 1'b0 || data_a !== '0 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy %b val %b last %b data %h busy %b want 1 0 0 00 0",
               rdy_a, val_a, last_a, data_a, busy_a);
    end
    for (int i = 0; i < N; i++) begin
      n_vec++;
      if (sd_a[i] !== 8'hFF || sd_d[i] !== 8'h00) begin
        n_err++;
        $display("FAIL reset_pad[%0d]: got %h/%h want ff/00", i, sd_a[i], sd_d[i]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_job();
    vec_t v;
    int   k;
    v = '{8'd35, 8'd120, 8'd0, 8'd0, 8'd55, 8'd100, 8'd77, 8'd5};
    send_job(v, 8, 1'b0, 1'b1);
    k = 0;
    while (!val_a && k < 100) begin
      n_vec++;
      if (rdy_a !== 1'b0 || busy_a !== 1'b1 || sd_a[1] !== 8'd120) begin
        n_err++;
        $display("FAIL wait_state: rdy %b busy %b sort[1] %h want 0 1 78", rdy_a, busy_a, sd_a[1]);
      end
      @(posedge clk); #1;
      k++;
    end
    n_vec++;
    if (k != LAT) begin
      n_err++;
      $display("FAIL first_valid_latency: got %0d edges want %0d", k, LAT);
    end
    drain(8, 1'b0, 1'b1);
  endtask

  task automatic test_short_job();
    vec_t v;
    v = '{8'd9, 8'd2, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_job(v, 3, 1'b1, 1'b1);
    drain(3, 1'b0, 1'b1);
    repeat (4) begin
      n_vec++;
      if (val_a !== 1'b0 || val_d !== 1'b0) begin
        n_err++;
        $display("FAIL pad_not_emitted: valid %b/%b want 0/0", val_a, val_d);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    vec_t v;
    v = '{8'd35, 8'd120, 8'd0, 8'd0, 8'd55, 8'd100, 8'd77, 8'd5};
    send_job(v, 8, 1'b0, 1'b1);
    drain(8, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    vec_t v;
    v = '{8'd0, 8'd4, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_job(v, 3, 1'b1, 1'b1);
    drain(3, 1'b0, 1'b1);
    v = '{8'd200, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_job(v, 2, 1'b1, 1'b1);
    drain(2, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    vec_t v;
    v = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_job(v, 3, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if (rdy_a !== 1'b1 || val_a !== 1'b0 || busy_a !== 1'b0 || sd_a[0] !== 8'hFF) begin
      n_err++;
      $display("FAIL flush_wait: rdy %b val %b busy %b sort[0] %h want 1 0 0 ff", rdy_a, val_a, busy_a, sd_a[0]);
    end
    // An input beat offered together with flush must be dropped.
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (sd_a[0] !== 8'hFF || sd_d[0] !== 8'h00 || rdy_a !== 1'b1) begin
      n_err++;
      $display("FAIL flush_drops_input: sort[0] %h/%h rdy %b want ff/00 1", sd_a[0], sd_d[0], rdy_a);
    end
    repeat (LAT + 4) begin
      n_vec++;
      if (val_a !== 1'b0 || val_d !== 1'b0) begin
        n_err++;
        $display("FAIL flushed_job_output: valid %b/%b want 0/0", val_a, val_d);
      end
      @(posedge clk); #1;
    end
    v = '{8'd10, 8'd20, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_job(v, 2, 1'b1, 1'b1);
    drain(2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid_drain();
    vec_t v;
    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    send_job(v, 8, 1'b0, 1'b1);
    drain(3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (val_a !== 1'b0 || val_d !== 1'b0 || rdy_a !== 1'b1 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_mid_drain: valid %b/%b rdy %b busy %b want 0/0 1 0",
               val_a, val_d, rdy_a, busy_a);
    end
    q_a.delete();
    q_d.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    v = '{8'd250, 8'd1, 8'd128, 8'd64, 8'd32, 8'd16, 8'd8, 8'd4};
    send_job(v, 8, 1'b0, 1'b1);
    drain(8, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_short_job();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sort_stream_ctrl
